// File: rtl/dotp_pkg.sv
// dotp_pkg: shared types and constants for the sequential dot-product engine.
//   state_e     : FSM state encoding (IDLE, MUL, DONE)
//   acc_width() : result width 2*W + clog2(N), with N=1 contributing 0 bits
//   SEG_LUT     : active-low 7-segment glyphs, bit 6 = segment a ... bit 0 = g
package dotp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width that holds the sum of N products of two W-bit values without overflow.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned n);
    return (n > 1) ? (2 * w + $clog2(n)) : (2 * w);
  endfunction

  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/dotp_seq_seg7_decode.sv
// seg7_decode: combinational hex nibble to active-low 7-segment code.
//   nibble_i [3:0] : value to display
//   seg_c_o  [6:0] : segments a..g (bit 6 = a), low = lit
module seg7_decode
  import dotp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_c_o
);

  assign seg_c_o = SEG_LUT[nibble_i];

endmodule

// File: rtl/dotp_seq.sv
// dotp_seq: sequential unsigned dot product P = sum A[i]*B[i] over N pairs of
// W-bit operands, one shift-add step per cycle (N*W cycles per operation).
// Optional hex display output enabled by macro DOTP_HEX_EN.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : operand handshake (a_in, b_in packed, pair i at [i*W +: W])
//   out_valid/out_ready : result handshake, result held while out_valid
//   result [ACC_W-1:0]  : accumulated dot product
//   busy              : high while iterating (MUL state)
//   hex [7*NDIG-1:0]  : (DOTP_HEX_EN only) active-low digits, LSD in low 7 bits
module dotp_seq
  import dotp_pkg::*;
#(
  parameter  int unsigned W     = 4,
  parameter  int unsigned N     = 2,
  localparam int unsigned ACC_W = acc_width(W, N)
`ifdef DOTP_HEX_EN
  ,
  localparam int unsigned NDIG  = (ACC_W + 3) / 4
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*W-1:0]     a_in,
  input  logic [N*W-1:0]     b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   result,
  output logic               busy
`ifdef DOTP_HEX_EN
  ,
  output logic [7*NDIG-1:0]  hex
`endif
);

  localparam int unsigned K_W = $clog2(W);
  localparam int unsigned P_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q, state_d;
  logic [N*W-1:0]     a_q, a_d;
  logic [N*W-1:0]     b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [P_W-1:0]     p_q, p_d;
  logic [K_W-1:0]     k_q, k_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  // Operand registers shift as they are consumed: the current pair always sits
  // in the low W bits of a_q, and the current multiplier bit in b_q[0].
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    k_d     = k_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          acc_d   = '0;
          p_d     = '0;
          k_d     = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (b_q[0]) begin
          acc_d = acc_q + (ACC_W'(a_q[W-1:0]) << k_q);
        end
        b_d = b_q >> 1;
        if (k_q == K_W'(W - 1)) begin
          k_d = '0;
          a_d = a_q >> W;
          if (p_q == P_W'(N - 1)) begin
            p_d     = '0;
            state_d = DONE;
          end else begin
            p_d = p_q + P_W'(1);
          end
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of the next state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == MUL);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = acc_q;

`ifdef DOTP_HEX_EN
  // Hex digits decoded directly from the result register.
  logic [4*NDIG-1:0] res_pad;
  assign res_pad = (4*NDIG)'(acc_q);

  for (genvar j = 0; j < NDIG; j++) begin : g_digit
    seg7_decode u_seg (
      .nibble_i (res_pad[4*j +: 4]),
      .seg_c_o  (hex[7*j +: 7])
    );
  end
`endif

endmodule

// File: tb/tb_dotp_seq.sv
module tb_dotp_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DUT 0: W=4, N=2 (ACC_W=9)
  logic        iv0, ir0, ov0, or0, bz0;
  logic [7:0]  a0, b0;
  logic [8:0]  r0;
  // DUT 1: W=8, N=4 (ACC_W=18)
  logic        iv1, ir1, ov1, or1, bz1;
  logic [31:0] a1, b1;
  logic [17:0] r1;
`ifdef DOTP_HEX_EN
  logic [20:0] hex0;
  logic [34:0] hex1;
`endif

  dotp_seq #(.W(4), .N(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a_in(a0), .b_in(b0),
    .out_valid(ov0), .out_ready(or0), .result(r0), .busy(bz0)
`ifdef DOTP_HEX_EN
    , .hex(hex0)
`endif
  );

  dotp_seq #(.W(8), .N(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a_in(a1), .b_in(b1),
    .out_valid(ov1), .out_ready(or1), .result(r1), .busy(bz1)
`ifdef DOTP_HEX_EN
    , .hex(hex1)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference: plain sum of products over unpacked operand fields.
  function automatic int unsigned model(input logic [31:0] a, input logic [31:0] b,
                                        input int w, input int n);
    int unsigned s = 0;
    int unsigned mask = (1 << w) - 1;
    for (int i = 0; i < n; i++)
      s += ((a >> (i * w)) & mask) * ((b >> (i * w)) & mask);
    return s;
  endfunction

`ifdef DOTP_HEX_EN
  function automatic logic [6:0] seg(input int unsigned d);
    case (d)
      0: return 7'b0000001;   1: return 7'b1001111;   2: return 7'b0010010;
      3: return 7'b0000110;   4: return 7'b1001100;   5: return 7'b0100100;
      6: return 7'b0100000;   7: return 7'b0001111;   8: return 7'b0000000;
      9: return 7'b0000100;  10: return 7'b0001000;  11: return 7'b1100000;
     12: return 7'b0110001;  13: return 7'b1000010;  14: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [63:0] hex_model(input int unsigned v, input int ndig);
    logic [63:0] h = '0;
    for (int j = 0; j < ndig; j++)
      h |= 64'(seg((v >> (4 * j)) & 15)) << (7 * j);
    return h;
  endfunction
`endif

  // One operation on dut0; inj >= 0 pulses in_valid with junk at that MUL cycle.
  task automatic op0(input logic [7:0] a, input logic [7:0] b, input int unsigned exp,
                     input int stall, input int inj, input string nm);
    int e, bc;
    logic [8:0] held;
    @(negedge clk);
    chk({nm, " in_ready_idle"}, 64'(ir0), 64'd1);
    iv0 = 1'b1; a0 = a; b0 = b;
    @(negedge clk);
    iv0 = 1'b0; a0 = 8'($urandom); b0 = 8'($urandom);
    e = 0; bc = 0;
    while (!ov0 && e < 100) begin
      if (bz0) bc++;
      iv0 = (e == inj);
      @(negedge clk);
      e++;
    end
    iv0 = 1'b0;
    chk({nm, " latency"}, 64'(e), 64'd8);
    chk({nm, " busy_cycles"}, 64'(bc), 64'd8);
    chk({nm, " result"}, 64'(r0), 64'(exp));
`ifdef DOTP_HEX_EN
    chk({nm, " hex"}, 64'(hex0), hex_model(exp, 3));
`endif
    held = r0;
    or0 = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({nm, " stall_valid"}, 64'(ov0), 64'd1);
      chk({nm, " stall_result"}, 64'(r0), 64'(held));
      chk({nm, " stall_in_ready"}, 64'(ir0), 64'd0);
    end
    or0 = 1'b1;
    @(negedge clk);
    or0 = 1'b0;
    chk({nm, " post_in_ready"}, 64'(ir0), 64'd1);
    chk({nm, " post_valid"}, 64'(ov0), 64'd0);
    chk({nm, " post_result_kept"}, 64'(r0), 64'(exp));
  endtask

  task automatic op1(input logic [31:0] a, input logic [31:0] b, input int unsigned exp,
                     input string nm);
    int e;
    @(negedge clk);
    iv1 = 1'b1; a1 = a; b1 = b;
    @(negedge clk);
    iv1 = 1'b0;
    e = 0;
    while (!ov1 && e < 200) begin
      @(negedge clk);
      e++;
    end
    chk({nm, " latency"}, 64'(e), 64'd32);
    chk({nm, " result"}, 64'(r1), 64'(exp));
`ifdef DOTP_HEX_EN
    chk({nm, " hex"}, 64'(hex1), hex_model(exp, 5));
`endif
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
    chk({nm, " post_in_ready"}, 64'(ir1), 64'd1);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int unsigned exp;
    int          stall;
    int          inj;
    string       nm;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iv0 = 1'b0; or0 = 1'b0; a0 = '0; b0 = '0;
    iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", 64'(ir0), 64'd1);
    chk("reset out_valid", 64'(ov0), 64'd0);
    chk("reset busy", 64'(bz0), 64'd0);
    chk("reset result", 64'(r0), 64'd0);
    chk("reset1 in_ready", 64'(ir1), 64'd1);
    chk("reset1 result", 64'(r1), 64'd0);
`ifdef DOTP_HEX_EN
    chk("reset hex", 64'(hex0), hex_model(0, 3));
`endif
    rst = 1'b0;

    tbl[0] = '{a: 8'h73, b: 8'h25, exp: 29,  stall: 0, inj: -1, nm: "vec_basic"};
    tbl[1] = '{a: 8'hFF, b: 8'hFF, exp: 450, stall: 5, inj: -1, nm: "vec_allF_stall"};
    tbl[2] = '{a: 8'h00, b: 8'h00, exp: 0,   stall: 0, inj: -1, nm: "vec_zero"};
    tbl[3] = '{a: 8'h11, b: 8'h11, exp: 2,   stall: 1, inj: -1, nm: "vec_ones"};
    tbl[4] = '{a: 8'h73, b: 8'h25, exp: 29,  stall: 0, inj: 3,  nm: "vec_inject"};
    for (int i = 0; i < 5; i++)
      op0(tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].stall, tbl[i].inj, tbl[i].nm);

    // Reset mid-MUL aborts the operation.
    @(negedge clk);
    iv0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF;
    @(negedge clk);
    iv0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst busy_before", 64'(bz0), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst out_valid", 64'(ov0), 64'd0);
    chk("midrst result", 64'(r0), 64'd0);
    chk("midrst in_ready", 64'(ir0), 64'd1);
    chk("midrst busy", 64'(bz0), 64'd0);
    op0(8'h11, 8'h11, 2, 0, -1, "after_rst");

    // Reset dominates a same-cycle in_valid.
    @(negedge clk);
    rst = 1'b1; iv0 = 1'b1; a0 = 8'h55; b0 = 8'h55;
    @(negedge clk);
    rst = 1'b0; iv0 = 1'b0;
    chk("rst_vs_valid in_ready", 64'(ir0), 64'd1);
    chk("rst_vs_valid busy", 64'(bz0), 64'd0);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      op0(ra, rb, model(32'(ra), 32'(rb), 4, 2), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 9)), "rand0");
    end

    op1(32'hFFFF_FFFF, 32'hFFFF_FFFF, 260100, "w8n4_allF");
    for (int i = 0; i < 5; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      op1(ra, rb, model(ra, rb, 8, 4), "rand1");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
